// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-target buffer: counter encodings,
// invalidate sequencer states and saturating counter arithmetic.
package bp_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } bp_state_e;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'b01;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter.
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   assign ctr_next = taken ? sat_inc(ctr) : sat_dec(ctr);

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, resolve-side
// training with registered mispredict flush, table-invalidate sequencer and stats.
module branch_predictor_btb
   import bp_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int ENTRIES = 16,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   f_pc,
   output logic [PC_W-1:0]   f_pred_pc,
   output logic              f_pred_taken,
   input  logic              res_valid,
   input  logic [PC_W-1:0]   res_pc,
   input  logic              res_taken,
   input  logic [PC_W-1:0]   res_target,
   input  logic              res_pred_taken,
   input  logic [PC_W-1:0]   res_pred_pc,
   input  logic              inv_req,
   output logic              flush,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              stall,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [PC_W-1:0]  tgt_q   [ENTRIES];
   logic [1:0]       ctr_q   [ENTRIES];

   bp_state_e        state_q, state_d;
   logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

   // Fetch lookup; forced to miss while the table is being invalidated.
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   assign f_idx        = f_pc[IDX_W+1:2];
   assign f_tag        = f_pc[PC_W-1:IDX_W+2];
   assign f_hit        = (state_q == IDLE) && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign f_pred_taken = f_hit && ctr_q[f_idx][1];
   assign f_pred_pc    = f_pred_taken ? tgt_q[f_idx] : f_pc + PC_W'(4);

   // res_valid qualifies the resolve bus for exactly the clock edge it is high
   // on; there is no back-pressure, every presented branch is consumed.
   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tag;
   logic             r_hit;
   logic [1:0]       r_ctr_next;
   logic [PC_W-1:0]  correct_pc;
   logic             mispredict;

   assign r_idx      = res_pc[IDX_W+1:2];
   assign r_tag      = res_pc[PC_W-1:IDX_W+2];
   assign r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
   assign correct_pc = res_taken ? res_target : res_pc + PC_W'(4);
   assign mispredict = res_valid &&
                       ((res_pred_taken != res_taken) || (res_pred_pc != correct_pc));

   bp_sat_counter u_res_ctr (
      .ctr      (ctr_q[r_idx]),
      .taken    (res_taken),
      .ctr_next (r_ctr_next)
   );

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         IDLE: begin
            if (inv_req) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end
         end
         CLEAR: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   assign stall = (state_q == CLEAR);

   // Resolve writes are dropped during CLEAR so the sweep leaves a clean table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= WNT;
         end
      end else if (state_q == CLEAR) begin
         valid_q[clr_ptr_q] <= 1'b0;
         ctr_q[clr_ptr_q]   <= WNT;
      end else if (res_valid) begin
         if (r_hit) begin
            ctr_q[r_idx] <= r_ctr_next;
            if (res_taken) tgt_q[r_idx] <= res_target;
         end else if (res_taken) begin
            valid_q[r_idx] <= 1'b1;
            tag_q[r_idx]   <= r_tag;
            tgt_q[r_idx]   <= res_target;
            ctr_q[r_idx]   <= WT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush            <= 1'b0;
         redirect_pc      <= '0;
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         flush <= mispredict;
         if (mispredict) redirect_pc <= correct_pc;
         if (res_valid && (stat_branches != '1))
            stat_branches <= stat_branches + STAT_W'(1);
         if (mispredict && (stat_mispredicts != '1))
            stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: reference table model, flush/redirect
// scoreboard queue, invalidate timing, async reset and stat saturation scenarios.
module tb_branch_predictor_btb;

   localparam int PC_W    = 32;
   localparam int ENTRIES = 16;
   localparam int STAT_W  = 4;
   localparam int STAT_MAX = 15;

   logic              clk;
   logic              rst_n;
   logic [PC_W-1:0]   f_pc;
   logic [PC_W-1:0]   f_pred_pc;
   logic              f_pred_taken;
   logic              res_valid;
   logic [PC_W-1:0]   res_pc;
   logic              res_taken;
   logic [PC_W-1:0]   res_target;
   logic              res_pred_taken;
   logic [PC_W-1:0]   res_pred_pc;
   logic              inv_req;
   logic              flush;
   logic [PC_W-1:0]   redirect_pc;
   logic              stall;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispredicts;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q[$];

   logic        m_valid [ENTRIES];
   logic [25:0] m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   logic [1:0]  m_ctr   [ENTRIES];
   int          m_br;
   int          m_mp;

   branch_predictor_btb #(
      .PC_W    (PC_W),
      .ENTRIES (ENTRIES),
      .STAT_W  (STAT_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .f_pc             (f_pc),
      .f_pred_pc        (f_pred_pc),
      .f_pred_taken     (f_pred_taken),
      .res_valid        (res_valid),
      .res_pc           (res_pc),
      .res_taken        (res_taken),
      .res_target       (res_target),
      .res_pred_taken   (res_pred_taken),
      .res_pred_pc      (res_pred_pc),
      .inv_req          (inv_req),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .stall            (stall),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // reference model
   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 2'b01;
      end
   endtask

   function automatic void m_lookup(input logic [31:0] pc, output logic [31:0] ppc,
                                    output logic pt);
      logic [3:0] idx;
      idx = pc[5:2];
      pt  = m_valid[idx] && (m_tag[idx] == pc[31:6]) && m_ctr[idx][1];
      ppc = pt ? m_tgt[idx] : pc + 32'd4;
   endfunction

   task automatic m_update(input logic [31:0] pc, input logic taken, input logic [31:0] target);
      logic [3:0] idx;
      idx = pc[5:2];
      if (m_valid[idx] && (m_tag[idx] == pc[31:6])) begin
         if (taken) begin
            if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
            m_tgt[idx] = target;
         end else if (m_ctr[idx] != 2'b00) begin
            m_ctr[idx] = m_ctr[idx] - 2'b01;
         end
      end else if (taken) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = pc[31:6];
         m_tgt[idx]   = target;
         m_ctr[idx]   = 2'b10;
      end
   endtask

   // driver tasks
   task automatic check_lookup(input logic [31:0] pc, input string name);
      logic [31:0] e_pc;
      logic        e_t;
      f_pc = pc;
      #1;
      m_lookup(pc, e_pc, e_t);
      checks++;
      if (f_pred_pc !== e_pc || f_pred_taken !== e_t) begin
         errors++;
         $display("FAIL %s: pc=%h got pred_pc=%h taken=%b, want pred_pc=%h taken=%b",
                  name, pc, f_pred_pc, f_pred_taken, e_pc, e_t);
      end
   endtask

   task automatic resolve_ex(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                             input logic pred_t, input logic [31:0] pred_pc, input logic wr_en);
      logic [31:0] correct;
      logic        mp;
      logic [32:0] e;
      correct = taken ? target : pc + 32'd4;
      mp      = (pred_t != taken) || (pred_pc != correct);
      @(negedge clk);
      res_valid      = 1'b1;
      res_pc         = pc;
      res_taken      = taken;
      res_target     = target;
      res_pred_taken = pred_t;
      res_pred_pc    = pred_pc;
      exp_q.push_back({mp, correct});
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      if (wr_en) m_update(pc, taken, target);
      if (m_br < STAT_MAX) m_br++;
      if (mp && m_mp < STAT_MAX) m_mp++;
      e = exp_q.pop_front();
      checks++;
      if (flush !== e[32]) begin
         errors++;
         $display("FAIL flush pc=%h: got %b want %b", pc, flush, e[32]);
      end
      if (e[32]) begin
         checks++;
         if (redirect_pc !== e[31:0]) begin
            errors++;
            $display("FAIL redirect_pc pc=%h: got %h want %h", pc, redirect_pc, e[31:0]);
         end
      end
      checks++;
      if (stat_branches !== STAT_W'(m_br) || stat_mispredicts !== STAT_W'(m_mp)) begin
         errors++;
         $display("FAIL stats pc=%h: got br=%0d mp=%0d want br=%0d mp=%0d",
                  pc, stat_branches, stat_mispredicts, m_br, m_mp);
      end
   endtask

   task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target);
      logic [31:0] ppc;
      logic        pt;
      m_lookup(pc, ppc, pt);
      resolve_ex(pc, taken, target, pt, ppc, 1'b1);
   endtask

   // scenarios
   task automatic test_reset();
      rst_n = 1'b0; f_pc = '0; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
      res_target = '0; res_pred_taken = 1'b0; res_pred_pc = '0; inv_req = 1'b0;
      m_reset(); m_br = 0; m_mp = 0;
      #22;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      f_pc = 32'h10;
      #1;
      checks++;
      if (f_pred_pc !== 32'h14 || f_pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_lookup: got %h/%b want 00000014/0", f_pred_pc, f_pred_taken);
      end
      checks++;
      if (stall !== 1'b0 || flush !== 1'b0 || stat_branches !== '0 || stat_mispredicts !== '0) begin
         errors++;
         $display("FAIL reset_outputs: stall=%b flush=%b br=%0d mp=%0d want all 0",
                  stall, flush, stat_branches, stat_mispredicts);
      end
   endtask

   task automatic test_cold_taken();
      resolve(32'h10, 1'b1, 32'h20);
      @(posedge clk);
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL flush_one_cycle: got %b want 0", flush);
      end
      check_lookup(32'h10, "cold_trained");
      checks++;
      if (f_pred_pc !== 32'h20) begin
         errors++;
         $display("FAIL cold_target: got %h want 00000020", f_pred_pc);
      end
   endtask

   task automatic test_saturation();
      repeat (3) resolve(32'h10, 1'b1, 32'h20);
      check_lookup(32'h10, "sat_taken");
      resolve(32'h10, 1'b0, 32'h0);
      check_lookup(32'h10, "sat_one_nt");
      resolve(32'h10, 1'b0, 32'h0);
      check_lookup(32'h10, "sat_two_nt");
      checks++;
      if (f_pred_pc !== 32'h14 || f_pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL sat_weak_nt: got %h/%b want 00000014/0", f_pred_pc, f_pred_taken);
      end
      resolve(32'h10, 1'b1, 32'h20);
      check_lookup(32'h10, "sat_flip_back");
   endtask

   task automatic test_aliasing();
      resolve(32'h50, 1'b1, 32'h100);
      check_lookup(32'h10, "alias_evicted");
      checks++;
      if (f_pred_pc !== 32'h14) begin
         errors++;
         $display("FAIL alias_miss: got %h want 00000014", f_pred_pc);
      end
      check_lookup(32'h50, "alias_new");
      resolve(32'h24, 1'b1, 32'h300);
   endtask

   task automatic test_invalidate();
      int stall_cycles;
      stall_cycles = 0;
      @(negedge clk);
      inv_req = 1'b1;
      @(posedge clk);
      #1;
      inv_req = 1'b0;
      m_reset();
      for (int c = 0; c < 25; c++) begin
         if (stall === 1'b1) begin
            stall_cycles++;
            f_pc = 32'h24;
            #1;
            checks++;
            if (f_pred_taken !== 1'b0 || f_pred_pc !== 32'h28) begin
               errors++;
               $display("FAIL clear_lookup c=%0d: got %h/%b want 00000028/0", c, f_pred_pc, f_pred_taken);
            end
         end
         if (c == 4) inv_req = 1'b1;
         if (c == 6) resolve_ex(32'h60, 1'b1, 32'h80, 1'b0, 32'h64, 1'b0);
         else begin
            @(posedge clk);
            #1;
         end
         inv_req = 1'b0;
      end
      checks++;
      if (stall_cycles != ENTRIES || stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_len: got %0d cycles (stall now %b) want %0d (0)", stall_cycles, stall, ENTRIES);
      end
      check_lookup(32'h60, "no_alloc_in_clear");
      check_lookup(32'h50, "cleared_50");
      check_lookup(32'h24, "cleared_24");
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      logic [31:0] tgt;
      for (int i = 0; i < 30; i++) begin
         pc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
         tgt = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
         check_lookup(pc, "b2b_lookup");
         resolve(pc, 1'($urandom_range(0, 1)), tgt);
      end
   endtask

   task automatic test_async_reset();
      resolve(32'h3C, 1'b1, 32'h200);
      check_lookup(32'h3C, "pre_reset_alloc");
      @(negedge clk);
      inv_req = 1'b1;
      @(posedge clk);
      #1;
      inv_req = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_before_reset: got %b want 1", stall);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || flush !== 1'b0 || stat_branches !== '0 || stat_mispredicts !== '0) begin
         errors++;
         $display("FAIL async_reset: stall=%b flush=%b br=%0d mp=%0d want all 0",
                  stall, flush, stat_branches, stat_mispredicts);
      end
      m_reset(); m_br = 0; m_mp = 0;
      check_lookup(32'h3C, "async_reset_table");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stat_saturation();
      for (int i = 0; i < 20; i++) resolve_ex(32'h80, 1'b0, 32'h0, 1'b1, 32'h999, 1'b1);
      checks++;
      if (stat_mispredicts !== 4'd15 || stat_branches !== 4'd15) begin
         errors++;
         $display("FAIL stat_saturate: got br=%0d mp=%0d want 15 15", stat_branches, stat_mispredicts);
      end
   endtask

   initial begin
      test_reset();
      test_cold_taken();
      test_saturation();
      test_aliasing();
      test_invalidate();
      test_back_to_back();
      test_async_reset();
      test_stat_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
